audio_nios_sd_cmd_engine: RTL and testbench



---
 rtl/audio_nios_sd_cmd_engine.sv | 159 +++++++++++++++
 tb/tb_audio_nios_sd_cmd_engine.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/audio_nios_sd_cmd_engine.sv
// audio_nios_sd_cmd_engine: Avalon-MM SD CMD-line engine that sends a 48-bit command with CRC7 and captures the 48-bit response
module audio_nios_sd_cmd_engine #(
  parameter int CLK_DIV      = 125,
  parameter int RESP_TIMEOUT = 64,
  parameter int NCC_CLOCKS   = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        sd_clk,
  output logic        cmd_out,
  output logic        cmd_oe,
  input  logic        cmd_in
);
  localparam logic [2:0] IDLE = 3'd0, SEND = 3'd1, WAIT_RESP = 3'd2, RECV = 3'd3, NCC = 3'd4;

  logic [15:0] div_q, div_d, cnt_q, cnt_d;
  logic        sd_clk_q, sd_clk_d, cmd_out_q, cmd_out_d, cmd_oe_q, cmd_oe_d;
  logic [2:0]  state_q, state_d;
  logic [47:0] tx_q, tx_d, rx_full;
  logic [46:0] rx_q, rx_d;
  logic [31:0] arg_q, arg_d, resp_q, resp_d, rd_q, rd_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [16:0] hdr_q, hdr_d;
  logic        done_q, done_d, to_q, to_d, crc_q, crc_d, end_q, end_d;
  logic        wrap, rise, fall, wr, busy, accept;
  logic        set_done, set_to, set_crc, set_end;
  logic [3:0]  clr;

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    c = '0;
    for (int i = 39; i >= 0; i--) c = {c[5:0], 1'b0} ^ ((d[i] ^ c[6]) ? 7'h09 : 7'h00);
    return c;
  endfunction

  always_comb begin
    wrap     = div_q == 16'(CLK_DIV - 1);
    rise     = wrap & ~sd_clk_q;
    fall     = wrap & sd_clk_q;
    wr       = chipselect & ~write_n;
    busy     = state_q != IDLE;
    accept   = wr & (address == 3'd1) & ~busy;
    clr      = (wr & (address == 3'd2)) ? writedata[4:1] : 4'b0;
    rx_full  = {rx_q, cmd_in};
    div_d    = wrap ? 16'd0 : div_q + 16'd1;
    sd_clk_d = sd_clk_q ^ wrap;
    arg_d    = (wr & (address == 3'd0) & ~busy) ? writedata : arg_q;
    cmd_d    = accept ? writedata[7:0] : cmd_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    resp_d   = resp_q;
    hdr_d    = hdr_q;
    cmd_out_d = cmd_out_q;
    cmd_oe_d = cmd_oe_q;
    set_done = 1'b0;
    set_to   = 1'b0;
    set_crc  = 1'b0;
    set_end  = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        tx_d    = {2'b01, writedata[5:0], arg_q, crc7({2'b01, writedata[5:0], arg_q}), 1'b1};
        cnt_d   = '0;
        state_d = SEND;
      end
      SEND: if (fall) begin
        cmd_oe_d  = cnt_q != 16'd48;
        cmd_out_d = (cnt_q == 16'd48) | tx_q[47];
        tx_d      = {tx_q[46:0], 1'b0};
        cnt_d     = (cnt_q == 16'd48) ? 16'd0 : cnt_q + 16'd1;
        state_d   = (cnt_q != 16'd48) ? SEND : cmd_q[6] ? WAIT_RESP : NCC;
      end
      WAIT_RESP: if (rise) begin
        set_to  = cmd_in & (cnt_q == 16'(RESP_TIMEOUT - 1));
        rx_d    = '0;
        cnt_d   = (~cmd_in | set_to) ? 16'd0 : cnt_q + 16'd1;
        state_d = ~cmd_in ? RECV : set_to ? NCC : WAIT_RESP;
      end
      RECV: if (rise) begin
        rx_d  = rx_full[46:0];
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == 16'd46) begin
          // the start bit was consumed on entry, so this is the end bit
          set_crc = (crc7(rx_full[47:8]) != rx_full[7:1]) & ~cmd_q[7];
          set_end = ~rx_full[0];
          resp_d  = rx_full[39:8];
          hdr_d   = {rx_full[46], rx_full[47], rx_full[7:1], 2'b00, rx_full[45:40]};
          cnt_d   = '0;
          state_d = NCC;
        end
      end
      NCC: if (rise) begin
        set_done = cnt_q == 16'(NCC_CLOCKS - 1);
        cnt_d    = set_done ? 16'd0 : cnt_q + 16'd1;
        state_d  = set_done ? IDLE : NCC;
      end
      default: state_d = IDLE;
    endcase
    done_d = set_done | (done_q & ~clr[0] & ~accept);
    to_d   = set_to   | (to_q   & ~clr[1] & ~accept);
    crc_d  = set_crc  | (crc_q  & ~clr[2] & ~accept);
    end_d  = set_end  | (end_q  & ~clr[3] & ~accept);
    rd_d   = (address == 3'd0) ? arg_q :
             (address == 3'd1) ? {24'b0, cmd_q} :
             (address == 3'd2) ? {27'b0, end_q, crc_q, to_q, done_q, busy} :
             (address == 3'd3) ? resp_q :
             (address == 3'd4) ? {15'b0, hdr_q} : 32'b0;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      div_q     <= '0;
      cnt_q     <= '0;
      sd_clk_q  <= 1'b0;
      cmd_out_q <= 1'b1;
      cmd_oe_q  <= 1'b0;
      state_q   <= IDLE;
      tx_q      <= '0;
      rx_q      <= '0;
      arg_q     <= '0;
      resp_q    <= '0;
      rd_q      <= '0;
      cmd_q     <= '0;
      hdr_q     <= '0;
      done_q    <= 1'b0;
      to_q      <= 1'b0;
      crc_q     <= 1'b0;
      end_q     <= 1'b0;
    end else begin
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      sd_clk_q  <= sd_clk_d;
      cmd_out_q <= cmd_out_d;
      cmd_oe_q  <= cmd_oe_d;
      state_q   <= state_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      arg_q     <= arg_d;
      resp_q    <= resp_d;
      rd_q      <= rd_d;
      cmd_q     <= cmd_d;
      hdr_q     <= hdr_d;
      done_q    <= done_d;
      to_q      <= to_d;
      crc_q     <= crc_d;
      end_q     <= end_d;
    end

  assign readdata = rd_q;
  assign sd_clk   = sd_clk_q;
  assign cmd_out  = cmd_out_q;
  assign cmd_oe   = cmd_oe_q;
endmodule

// File: tb/tb_audio_nios_sd_cmd_engine.sv
// tb_audio_nios_sd_cmd_engine: scoreboard bench with an SD card model and a long-division CRC7 reference
module tb_audio_nios_sd_cmd_engine;
  logic        clk = 0, reset_n = 0, chipselect = 0, write_n = 1, cmd_in = 1;
  logic [2:0]  address = 0;
  logic [31:0] writedata = 0, readdata;
  logic        sd_clk, cmd_out, cmd_oe;

  typedef struct {bit v; logic [47:0] f;} card_t;

  int checks = 0, fails = 0, rises = 0, rel = 0, nb = 0;
  logic [47:0] cap, fq[$];
  logic [31:0] exp_q[$];
  string       name_q[$];
  card_t       card_q[$];
  logic        rd_req = 0, rd_seen = 0;
  event        frame_end;

  audio_nios_sd_cmd_engine #(.CLK_DIV(2), .RESP_TIMEOUT(64), .NCC_CLOCKS(8)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(readdata), .sd_clk(sd_clk), .cmd_out(cmd_out), .cmd_oe(cmd_oe),
    .cmd_in(cmd_in));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", n, act, exp);
    end
  endtask

  // CRC7 as polynomial long division of data*x^7 by x^7+x^3+1
  function automatic logic [6:0] crc7m(input logic [39:0] d);
    logic [46:0] r;
    r = {d, 7'b0};
    for (int i = 46; i >= 7; i--) if (r[i]) r[i-:8] ^= 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [47:0] mf(input logic [5:0] idx, input logic [31:0] arg);
    return {2'b01, idx, arg, crc7m({2'b01, idx, arg}), 1'b1};
  endfunction

  always @(posedge clk) rd_seen <= rd_req;

  always @(negedge clk)
    if (rd_seen) begin
      if (exp_q.size() == 0) chk("read_queue_empty", 1, 0);
      else chk(name_q.pop_front(), readdata, exp_q.pop_front());
    end

  always @(posedge sd_clk or negedge reset_n)
    if (!reset_n) begin
      nb = 0;
      fq.delete();
    end else begin
      rises++;
      if (cmd_oe) begin
        cap = {cap[46:0], cmd_out};
        nb++;
      end else if (nb > 0) begin
        chk("oe_cycles", nb, 48);
        if (fq.size() == 0) chk("unexpected_frame", 1, 0);
        else chk("frame", cap, fq.pop_front());
        rel = rises;
        nb = 0;
        ->frame_end;
      end
    end

  initial forever begin
    card_t c;
    @(frame_end);
    if (card_q.size() > 0) begin
      c = card_q.pop_front();
      if (c.v) begin
        repeat (2) @(negedge sd_clk);
        for (int i = 47; i >= 0; i--) begin
          @(negedge sd_clk);
          cmd_in = c.f[i];
        end
        @(negedge sd_clk);
        cmd_in = 1;
      end
    end
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1; write_n = 0;
    @(negedge clk);
    chipselect = 0; write_n = 1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string n);
    @(negedge clk);
    address = a; chipselect = 1; rd_req = 1;
    exp_q.push_back(e); name_q.push_back(n);
    @(negedge clk);
    rd_req = 0; chipselect = 0;
  endtask

  task automatic run(input logic [5:0] idx, input logic [31:0] arg, input bit re, input bit ign,
                     input logic [47:0] ef, input bit cv, input logic [47:0] cf);
    card_t c;
    c.v = cv; c.f = cf;
    fq.push_back(ef);
    card_q.push_back(c);
    wr(0, arg);
    wr(1, {24'b0, ign, re, idx});
  endtask

  task automatic wait_idle(input int gap, input bit use_gap);
    bit ok = 0;
    @(negedge clk);
    address = 2;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (!readdata[0]) begin ok = 1; break; end
    end
    chk("idle_wait", ok, 1);
    if (use_gap) chk("done_gap", rises - rel, gap);
  endtask

  task automatic wait_oe(input int bits);
    bit ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (cmd_oe) begin ok = 1; break; end
    end
    chk("oe_wait", ok, 1);
    repeat (bits * 4) @(negedge clk);
  endtask

  initial begin
    logic [5:0]  idx, ridx;
    logic [31:0] arg, rarg, a2, m_resp, m_hdr, st;
    logic [6:0]  c7;
    bit          re, ign, flip, eb;
    int          bp;
    m_resp = 0;
    repeat (3) @(negedge clk);
    chk("rst_sd_clk", sd_clk, 0);
    chk("rst_cmd_out", cmd_out, 1);
    chk("rst_cmd_oe", cmd_oe, 0);
    chk("rst_readdata", readdata, 0);
    reset_n = 1;
    rd(2, 0, "rst_status"); rd(0, 0, "rst_arg"); rd(1, 0, "rst_cmd");
    rd(3, 0, "rst_resp"); rd(4, 0, "rst_hdr");
    wr(5, 32'hFFFF_FFFF);
    rd(5, 0, "addr5"); rd(7, 0, "addr7");

    run(6'd0, 32'h0, 0, 0, 48'h400000000095, 0, 0);
    wait_idle(7, 1);
    rd(2, 32'h2, "cmd0_status");

    c7 = crc7m({2'b00, 6'd8, 32'h1AA});
    m_hdr = {15'b0, 1'b0, 1'b0, c7, 2'b00, 6'd8};
    run(6'd8, 32'h1AA, 1, 0, 48'h48000001AA87, 1, {2'b00, 6'd8, 32'h1AA, c7, 1'b1});
    wait_idle(0, 0);
    m_resp = 32'h1AA;
    rd(3, m_resp, "cmd8_resp"); rd(4, m_hdr, "cmd8_hdr"); rd(2, 32'h2, "cmd8_status");

    for (int k = 0; k < 2; k++) begin
      run(6'd8, 32'h1AA, 1, k[0], 48'h48000001AA87, 1, {2'b00, 6'd8, 32'h1AA ^ 32'h10, c7, 1'b1});
      wait_idle(0, 0);
      m_resp = 32'h1AA ^ 32'h10;
      rd(3, m_resp, "flip_resp");
      rd(2, k == 0 ? 32'hA : 32'h2, "flip_status");
    end

    for (int k = 0; k < 8; k++) begin
      idx = 6'($urandom_range(0, 63)); arg = $urandom;
      re = 1'($urandom_range(0, 1)); ign = 1'($urandom_range(0, 1));
      flip = $urandom_range(0, 2) == 0; eb = $urandom_range(0, 3) == 0;
      bp = $urandom_range(0, 31);
      ridx = 6'($urandom_range(0, 63)); rarg = $urandom;
      c7 = crc7m({2'b00, ridx, rarg});
      a2 = flip ? rarg ^ (32'h1 << bp) : rarg;
      run(idx, arg, re, ign, mf(idx, arg), re, {2'b00, ridx, a2, c7, ~eb});
      wait_idle(7, !re);
      st = 32'h2;
      if (re) begin
        m_resp = a2;
        m_hdr = {15'b0, 1'b0, 1'b0, c7, 2'b00, ridx};
        st = st | ((flip && !ign) ? 32'h8 : 0) | (eb ? 32'h10 : 0);
      end
      rd(2, st, "rnd_status"); rd(3, m_resp, "rnd_resp"); rd(4, m_hdr, "rnd_hdr");
      rd(1, {24'b0, ign, re, idx}, "rnd_cmd"); rd(0, arg, "rnd_arg");
    end

    run(6'd55, 32'h1234_5678, 1, 0, mf(6'd55, 32'h1234_5678), 0, 0);
    wait_idle(71, 1);
    rd(2, 32'h6, "timeout_status"); rd(3, m_resp, "timeout_resp");

    run(6'd17, 32'hCAFE_0001, 0, 0, mf(6'd17, 32'hCAFE_0001), 0, 0);
    wait_oe(5);
    wr(0, 32'hDEAD_BEEF);
    wr(1, 32'h0000_007F);
    rd(0, 32'hCAFE_0001, "busy_arg"); rd(1, 32'h11, "busy_cmd");
    wait_idle(7, 1);
    rd(2, 32'h2, "busy_status");
    wr(2, 32'h1E);
    rd(2, 32'h0, "clear_status");

    run(6'd2, 32'h0F0F_0F0F, 0, 0, mf(6'd2, 32'h0F0F_0F0F), 0, 0);
    wait_oe(10);
    #2 reset_n = 0;
    #1;
    chk("abort_sd_clk", sd_clk, 0);
    chk("abort_cmd_oe", cmd_oe, 0);
    chk("abort_cmd_out", cmd_out, 1);
    chk("abort_readdata", readdata, 0);
    card_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1;
    rd(2, 0, "abort_status"); rd(0, 0, "abort_arg");
    run(6'd41, 32'h8000_0001, 0, 0, mf(6'd41, 32'h8000_0001), 0, 0);
    wait_idle(7, 1);
    rd(2, 32'h2, "after_abort_status");

    repeat (4) @(negedge clk);
    chk("frames_pending", fq.size(), 0);
    chk("reads_pending", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
